// File: rtl/sti_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sti_pkg
// Description : Shared definitions for the STI serial receiver: frame length
//               codes, receiver state encoding and a helper that maps a
//               length code to the index of the last bit of the frame.
// Revision    : 1.0 - initial release
// ============================================================================
package sti_pkg;

  // Frame length codes as carried on cfg_length
  localparam logic [1:0] LEN_8  = 2'b00;
  localparam logic [1:0] LEN_16 = 2'b01;
  localparam logic [1:0] LEN_24 = 2'b10;
  localparam logic [1:0] LEN_32 = 2'b11;

  // Receiver state encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RECV = 2'd1;
  localparam logic [1:0] ST_OUT  = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RECV = ST_RECV,
    OUT  = ST_OUT
  } sti_state_e;

  // Frame length code -> L-1, the bit-counter preload value
  function automatic logic [4:0] len_to_last(input logic [1:0] code);
    logic [4:0] last;
    case (code)
      LEN_8:   last = 5'd7;
      LEN_16:  last = 5'd15;
      LEN_24:  last = 5'd23;
      default: last = 5'd31;
    endcase
    return last;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sti_rx_if.sv
`default_nettype none
// ============================================================================
// Module      : sti_rx_if
// Description : Serial-in / parallel-out bundle of the STI receiver.
//               master : drives the serial stream, observes the payload
//               slave  : the receiver (samples si_*, drives po_*)
// Signals     : si_data  - serial bit
//               si_valid - si_data valid this cycle
//               po_data  - reassembled 16-bit payload
//               po_valid - one-cycle payload strobe
// Revision    : 1.0 - initial release
// ============================================================================
interface sti_rx_if;
  logic        si_data;
  logic        si_valid;
  logic [15:0] po_data;
  logic        po_valid;

  modport master (
    output si_data,
    output si_valid,
    input  po_data,
    input  po_valid
  );

  modport slave (
    input  si_data,
    input  si_valid,
    output po_data,
    output po_valid
  );
endinterface
`default_nettype wire

// File: rtl/sti_rx_shifter.sv
`default_nettype none
// ============================================================================
// Module      : sti_rx_shifter
// Description : 32-bit receive shift register with MSB-first / LSB-first
//               insertion and a down-counting bit counter.
// Ports       : clk, reset   - clock, synchronous active-high reset
//               load         - clear register, preload counter from load_len
//               load_len     - frame length code used at load
//               msb_first    - 1: shift left inserting at bit 0
//                              0: bit n of the frame written to word[n]
//               shift_en     - accept bit_in this cycle
//               bit_in       - serial bit
//               word         - received bits, first bit ends up in word[L-1]
//                              (msb_first) or word[0] (lsb first)
//               done         - counter is zero: the next bit is the last one
// Revision    : 1.0 - initial release
// ============================================================================
module sti_rx_shifter
  import sti_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [1:0]  load_len,
  input  logic        msb_first,
  input  logic        shift_en,
  input  logic        bit_in,
  output logic [31:0] word,
  output logic        done
);

  logic [31:0] sr_q,  sr_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [4:0]  idx_q, idx_d;   // bits received so far, LSB-first write index

  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    idx_d = idx_q;
    if (load) begin
      sr_d  = '0;
      cnt_d = len_to_last(load_len);
      idx_d = '0;
    end else if (shift_en) begin
      if (msb_first) begin
        sr_d = {sr_q[30:0], bit_in};
      end else begin
        sr_d[idx_q] = bit_in;
      end
      // Counter parks at zero once the last bit is taken
      if (cnt_q != 5'd0) begin
        cnt_d = cnt_q - 5'd1;
      end
      idx_d = idx_q + 5'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sr_q  <= '0;
      cnt_q <= '0;
      idx_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
    end
  end

  assign word = sr_q;
  assign done = (cnt_q == 5'd0);

endmodule
`default_nettype wire

// File: rtl/sti_rx.sv
`default_nettype none
// ============================================================================
// Module      : sti_rx
// Description : STI serial-to-parallel receiver. Rebuilds a 16-bit payload
//               from 8/16/24/32-bit frames in either bit order and emits it
//               with a single-cycle po_valid strobe.
// Parameters  : TIMEOUT - idle cycles allowed mid-frame before abort (0: off)
// Ports       : clk, reset    - clock, synchronous active-high reset
//               cfg_load      - latch cfg_* and start a frame (IDLE only)
//               cfg_length    - 00=8, 01=16, 10=24, 11=32 bits
//               cfg_fill      - 24/32-bit: 1 payload in upper 16 bits
//               cfg_msb       - 1: first bit is word MSB
//               cfg_low       - 8-bit: 1 byte goes to po_data[15:8]
//               sif (slave)   - si_data/si_valid in, po_data/po_valid out
//               busy          - frame in progress (RECV or OUT)
//               stray_err     - pulse: si_valid outside RECV, bit dropped
//               timeout_err   - pulse: frame aborted by idle timeout
//               fill_err      - (STI_RX_FILL_CHECK_EN only) pulse with
//                               po_valid when a discarded bit is nonzero
// Options     : `define STI_RX_FILL_CHECK_EN adds the fill_err output
// Revision    : 1.0 - initial release
// ============================================================================
module sti_rx
  import sti_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cfg_load,
  input  logic [1:0] cfg_length,
  input  logic       cfg_fill,
  input  logic       cfg_msb,
  input  logic       cfg_low,
  sti_rx_if.slave    sif,
  output logic       busy,
  output logic       stray_err,
  output logic       timeout_err
`ifdef STI_RX_FILL_CHECK_EN
  ,
  output logic       fill_err
`endif
);

  logic [1:0]  state_q,       state_d;
  logic [1:0]  cfg_length_q,  cfg_length_d;
  logic        cfg_fill_q,    cfg_fill_d;
  logic        cfg_msb_q,     cfg_msb_d;
  logic        cfg_low_q,     cfg_low_d;
  logic [15:0] po_data_q,     po_data_d;
  logic        po_valid_q,    po_valid_d;
  logic        stray_err_q,   stray_err_d;
  logic        timeout_err_q, timeout_err_d;

  logic        w_sh_load;
  logic        w_sh_shift;
  logic [31:0] w_word;
  logic        w_last_bit;
  logic        w_timeout_hit;
  logic [15:0] w_payload;

  // --------------------------------------------------------------------------
  // Shift register / bit counter
  // --------------------------------------------------------------------------
  // The counter is preloaded straight from cfg_length because the config
  // registers only update on the same edge as the load.
  sti_rx_shifter u_shifter (
    .clk       (clk),
    .reset     (reset),
    .load      (w_sh_load),
    .load_len  (cfg_length),
    .msb_first (cfg_msb_q),
    .shift_en  (w_sh_shift),
    .bit_in    (sif.si_data),
    .word      (w_word),
    .done      (w_last_bit)
  );

  // --------------------------------------------------------------------------
  // Idle (gap) timeout
  // --------------------------------------------------------------------------
  generate
    if (TIMEOUT > 0) begin : g_timeout
      localparam int IW = $clog2(TIMEOUT + 1);
      logic [IW-1:0] idle_cnt_q, idle_cnt_d;

      // Counts consecutive RECV cycles without si_valid; any valid bit or
      // leaving RECV clears it.
      always_comb begin
        idle_cnt_d = '0;
        if (state_q == ST_RECV && !sif.si_valid) begin
          idle_cnt_d = idle_cnt_q + 1'b1;
        end
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          idle_cnt_q <= '0;
        end else begin
          idle_cnt_q <= idle_cnt_d;
        end
      end

      // Fires on the TIMEOUT-th consecutive idle cycle
      assign w_timeout_hit = (state_q == ST_RECV) && !sif.si_valid &&
                             (idle_cnt_q == IW'(TIMEOUT - 1));
    end else begin : g_no_timeout
      assign w_timeout_hit = 1'b0;
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Payload extraction from the received word
  // --------------------------------------------------------------------------
  always_comb begin
    w_payload = w_word[15:0];
    case (cfg_length_q)
      LEN_8:   w_payload = cfg_low_q  ? {w_word[7:0], 8'h00} : {8'h00, w_word[7:0]};
      LEN_16:  w_payload = w_word[15:0];
      LEN_24:  w_payload = cfg_fill_q ? w_word[23:8]  : w_word[15:0];
      default: w_payload = cfg_fill_q ? w_word[31:16] : w_word[15:0];
    endcase
  end

  // --------------------------------------------------------------------------
  // Control FSM
  // --------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    cfg_length_d  = cfg_length_q;
    cfg_fill_d    = cfg_fill_q;
    cfg_msb_d     = cfg_msb_q;
    cfg_low_d     = cfg_low_q;
    po_data_d     = po_data_q;
    po_valid_d    = 1'b0;
    stray_err_d   = 1'b0;
    timeout_err_d = 1'b0;
    w_sh_load     = 1'b0;
    w_sh_shift    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // A bit arriving here has no frame to land in, even alongside
        // cfg_load, since the shifter is being cleared on this edge.
        stray_err_d = sif.si_valid;
        if (cfg_load) begin
          cfg_length_d = cfg_length;
          cfg_fill_d   = cfg_fill;
          cfg_msb_d    = cfg_msb;
          cfg_low_d    = cfg_low;
          w_sh_load    = 1'b1;
          state_d      = ST_RECV;
        end
      end

      ST_RECV: begin
        if (sif.si_valid) begin
          w_sh_shift = 1'b1;
          if (w_last_bit) begin
            state_d = ST_OUT;
          end
        end else if (w_timeout_hit) begin
          timeout_err_d = 1'b1;
          state_d       = ST_IDLE;
        end
      end

      ST_OUT: begin
        stray_err_d = sif.si_valid;
        po_data_d   = w_payload;
        po_valid_d  = 1'b1;
        state_d     = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      cfg_length_q  <= '0;
      cfg_fill_q    <= 1'b0;
      cfg_msb_q     <= 1'b0;
      cfg_low_q     <= 1'b0;
      po_data_q     <= '0;
      po_valid_q    <= 1'b0;
      stray_err_q   <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cfg_length_q  <= cfg_length_d;
      cfg_fill_q    <= cfg_fill_d;
      cfg_msb_q     <= cfg_msb_d;
      cfg_low_q     <= cfg_low_d;
      po_data_q     <= po_data_d;
      po_valid_q    <= po_valid_d;
      stray_err_q   <= stray_err_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  // --------------------------------------------------------------------------
  // Optional fill-bit check
  // --------------------------------------------------------------------------
`ifdef STI_RX_FILL_CHECK_EN
  logic fill_err_q, fill_err_d;
  logic w_fill_bad;

  always_comb begin
    w_fill_bad = 1'b0;
    case (cfg_length_q)
      LEN_24:  w_fill_bad = cfg_fill_q ? (|w_word[7:0])  : (|w_word[23:16]);
      LEN_32:  w_fill_bad = cfg_fill_q ? (|w_word[15:0]) : (|w_word[31:16]);
      default: w_fill_bad = 1'b0;
    endcase
    fill_err_d = (state_q == ST_OUT) && w_fill_bad;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fill_err_q <= 1'b0;
    end else begin
      fill_err_q <= fill_err_d;
    end
  end

  assign fill_err = fill_err_q;
`endif

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign sif.po_data  = po_data_q;
  assign sif.po_valid = po_valid_q;
  assign busy         = (state_q == ST_RECV) || (state_q == ST_OUT);
  assign stray_err    = stray_err_q;
  assign timeout_err  = timeout_err_q;

endmodule
`default_nettype wire

// File: tb/tb_sti_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_sti_rx
// Description : Self-checking bench for sti_rx. Expected payloads are pushed
//               to a scoreboard queue when a frame is driven and popped when
//               po_valid is observed.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sti_rx;

  localparam int TIMEOUT = 64;

  logic       clk = 1'b0;
  logic       reset;
  logic       cfg_load;
  logic [1:0] cfg_length;
  logic       cfg_fill;
  logic       cfg_msb;
  logic       cfg_low;
  logic       busy;
  logic       stray_err;
  logic       timeout_err;
`ifdef STI_RX_FILL_CHECK_EN
  logic       fill_err;
`endif

  sti_rx_if sif ();

  sti_rx #(.TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .reset       (reset),
    .cfg_load    (cfg_load),
    .cfg_length  (cfg_length),
    .cfg_fill    (cfg_fill),
    .cfg_msb     (cfg_msb),
    .cfg_low     (cfg_low),
    .sif         (sif),
    .busy        (busy),
    .stray_err   (stray_err),
    .timeout_err (timeout_err)
`ifdef STI_RX_FILL_CHECK_EN
    ,
    .fill_err    (fill_err)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [15:0] data;
    logic        fill;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  int n_checks = 0;
  int n_pass   = 0;
  int pv_cyc   = -1;
  int pv_count = 0;
  int to_cyc   = -1;
  int to_count = 0;
  int last_edge = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [15:0] model_po(input logic [1:0] len, input logic fill,
                                           input logic low, input logic [31:0] w);
    case (len)
      2'b00:   return low ? {w[7:0], 8'h00} : {8'h00, w[7:0]};
      2'b01:   return w[15:0];
      2'b10:   return fill ? w[23:8] : w[15:0];
      default: return fill ? w[31:16] : w[15:0];
    endcase
  endfunction

  function automatic logic model_fill(input logic [1:0] len, input logic fill, input logic [31:0] w);
    case (len)
      2'b10:   return fill ? (|w[7:0])  : (|w[23:16]);
      2'b11:   return fill ? (|w[15:0]) : (|w[31:16]);
      default: return 1'b0;
    endcase
  endfunction

  // Output monitor: samples 1 time unit after each rising edge
  always begin
    @(posedge clk);
    #1;
    if (sif.po_valid === 1'b1) begin
      pv_cyc = cyc;
      pv_count++;
      if (exp_q.size() == 0) begin
        check_eq("po_valid_unexpected", 32'(sif.po_valid), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check_eq("po_data", 32'(sif.po_data), 32'(mon_e.data));
`ifdef STI_RX_FILL_CHECK_EN
        check_eq("fill_err", 32'(fill_err), 32'(mon_e.fill));
`endif
      end
    end
    if (timeout_err === 1'b1) begin
      to_cyc = cyc;
      to_count++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input logic [1:0] len, input logic fill, input logic msb, input logic low);
    cfg_load   = 1'b1;
    cfg_length = len;
    cfg_fill   = fill;
    cfg_msb    = msb;
    cfg_low    = low;
    tick();
    cfg_load   = 1'b0;
    // Flip the config inputs so only latched values can produce the result
    cfg_length = ~len;
    cfg_fill   = ~fill;
    cfg_msb    = ~msb;
    cfg_low    = ~low;
  endtask

  task automatic send_bits(input logic [31:0] w, input int n, input logic msb,
                           input int gap_at, input int gap_len, input bit load_mid);
    for (int i = 0; i < n; i++) begin
      if (i == gap_at) begin
        sif.si_valid = 1'b0;
        cfg_load     = 1'b0;
        repeat (gap_len) tick();
      end
      sif.si_valid = 1'b1;
      sif.si_data  = msb ? w[n-1-i] : w[i];
      cfg_load     = load_mid && (i == 3);
      tick();
    end
    last_edge    = cyc;
    sif.si_valid = 1'b0;
    sif.si_data  = 1'b0;
    cfg_load     = 1'b0;
  endtask

  task automatic run_frame(input logic [1:0] len, input logic fill, input logic msb,
                           input logic low, input logic [31:0] w, input int gap_at, input int gap_len);
    int n;
    logic [31:0] wm;
    exp_t e;
    n  = 8 * (int'(len) + 1);
    wm = (n == 32) ? w : (w & ((32'd1 << n) - 32'd1));
    e.data = model_po(len, fill, low, wm);
    e.fill = model_fill(len, fill, wm);
    exp_q.push_back(e);
    start_frame(len, fill, msb, low);
    send_bits(wm, n, msb, gap_at, gap_len, 1'b0);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    check_eq(tag, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    int   pv_before;
    exp_t e;
    reset        = 1'b1;
    cfg_load     = 1'b0;
    cfg_length   = 2'b00;
    cfg_fill     = 1'b0;
    cfg_msb      = 1'b0;
    cfg_low      = 1'b0;
    sif.si_valid = 1'b0;
    sif.si_data  = 1'b0;
    repeat (3) tick();
    check_eq("reset_flags", {28'd0, sif.po_valid, busy, stray_err, timeout_err}, 32'd0);
    check_eq("reset_po_data", 32'(sif.po_data), 32'd0);
    reset = 1'b0;
    tick();

    // 16-bit MSB-first frame, latency and busy timing
    e.data = 16'hA5C3; e.fill = 1'b0;
    exp_q.push_back(e);
    start_frame(2'b01, 1'b0, 1'b1, 1'b0);
    check_eq("busy_in_recv", 32'(busy), 32'd1);
    send_bits(32'h0000_A5C3, 16, 1'b1, -1, 0, 1'b0);
    tick();
    check_eq("po_valid_at_k1", 32'(sif.po_valid), 32'd1);
    check_eq("busy_after_out", 32'(busy), 32'd0);
    drain("drain_len16");
    check_eq("po_valid_latency", 32'(pv_cyc - last_edge), 32'd1);
    repeat (3) tick();
    check_eq("po_data_hold", 32'(sif.po_data), 32'h0000_A5C3);
    check_eq("po_valid_single", 32'(pv_count), 32'd1);

    // 8-bit LSB-first, both byte placements; stray bit during OUT
    run_frame(2'b00, 1'b0, 1'b0, 1'b1, 32'h0000_00A5, -1, 0);
    drain("drain_len8_low");
    run_frame(2'b00, 1'b0, 1'b0, 1'b0, 32'h0000_00A5, -1, 0);
    sif.si_valid = 1'b1;
    sif.si_data  = 1'b1;
    tick();
    sif.si_valid = 1'b0;
    sif.si_data  = 1'b0;
    check_eq("stray_in_out", {30'd0, stray_err, sif.po_valid}, 32'd3);
    drain("drain_len8_high");

    // 32/24-bit frames with fill placement, gaps and fill content
    run_frame(2'b11, 1'b1, 1'b1, 1'b0, 32'h1234_0000, 16, 3);
    drain("drain_len32_gap");
    run_frame(2'b11, 1'b1, 1'b1, 1'b0, 32'h1234_0100, 10, 2);
    drain("drain_len32_fillbit");
    run_frame(2'b10, 1'b1, 1'b1, 1'b0, 32'h00BE_EF12, -1, 0);
    drain("drain_len24_upper");
    run_frame(2'b10, 1'b0, 1'b0, 1'b0, 32'h0000_5A3C, -1, 0);
    drain("drain_len24_lower");
    run_frame(2'b11, 1'b0, 1'b0, 1'b0, 32'h8000_C3E1, -1, 0);
    drain("drain_len32_lower");

    // Timeout after 10 bits of a 24-bit frame
    pv_before = pv_count;
    to_count  = 0;
    start_frame(2'b10, 1'b0, 1'b1, 1'b0);
    send_bits(32'h0000_02AB, 10, 1'b1, -1, 0, 1'b0);
    for (int i = 0; i < 100 && to_count == 0; i++) tick();
    check_eq("timeout_latency", 32'(to_cyc - last_edge), 32'(TIMEOUT));
    check_eq("busy_after_timeout", 32'(busy), 32'd0);
    tick();
    check_eq("timeout_single", 32'(to_count), 32'd1);
    check_eq("no_po_valid_timeout", 32'(pv_count - pv_before), 32'd0);
    run_frame(2'b01, 1'b0, 1'b0, 1'b0, 32'h0000_3C5A, -1, 0);
    drain("drain_after_timeout");

    // Stray bits in IDLE, with and without cfg_load; cfg_load in RECV ignored
    sif.si_valid = 1'b1;
    sif.si_data  = 1'b1;
    tick();
    sif.si_valid = 1'b0;
    sif.si_data  = 1'b0;
    check_eq("stray_idle", 32'(stray_err), 32'd1);
    tick();
    check_eq("stray_pulse_end", {30'd0, stray_err, busy}, 32'd0);
    e.data = 16'h003C; e.fill = 1'b0;
    exp_q.push_back(e);
    cfg_load     = 1'b1;
    cfg_length   = 2'b00;
    cfg_fill     = 1'b0;
    cfg_msb      = 1'b1;
    cfg_low      = 1'b0;
    sif.si_valid = 1'b1;
    sif.si_data  = 1'b1;
    tick();
    cfg_load     = 1'b0;
    sif.si_valid = 1'b0;
    sif.si_data  = 1'b0;
    check_eq("stray_with_load", {30'd0, stray_err, busy}, 32'd3);
    cfg_length   = 2'b11;
    send_bits(32'h0000_003C, 8, 1'b1, -1, 0, 1'b1);
    drain("drain_load_in_recv");

    // Reset after 5 bits of a 24-bit frame
    pv_before = pv_count;
    start_frame(2'b10, 1'b0, 1'b1, 1'b0);
    send_bits(32'h00FF_FFFF, 5, 1'b1, -1, 0, 1'b0);
    reset = 1'b1;
    tick();
    check_eq("midreset_flags", {28'd0, sif.po_valid, busy, stray_err, timeout_err}, 32'd0);
    check_eq("midreset_po_data", 32'(sif.po_data), 32'd0);
    reset = 1'b0;
    repeat (3) tick();
    check_eq("no_po_valid_reset", 32'(pv_count - pv_before), 32'd0);
    run_frame(2'b10, 1'b0, 1'b1, 1'b0, 32'h0012_ABCD, -1, 0);
    drain("drain_after_reset");

    repeat (5) tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
